// File: rtl/core_ibuf.sv
// Instruction buffer between fetch and decode: a small in-order FIFO of
// {istr, pc} pairs with valid/ready on both sides and a single-cycle flush.
module core_ibuf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_ISTR = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rest,
   input  logic                     flush_en,
   input  logic [31:0]              in_istr,
   input  logic [31:0]              in_pc,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [31:0]              out_istr,
   output logic [31:0]              out_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      istr_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Both handshakes come from registered occupancy only, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign out_istr  = out_valid ? istr_mem[rd_ptr] : NOP_ISTR;
   assign out_pc    = out_valid ? pc_mem[rd_ptr]   : 32'h0;

   assign push = in_valid  & in_ready  & ~flush_en;
   assign pop  = out_valid & out_ready & ~flush_en;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale slots are never visible while count is 0.
   always_ff @(posedge clk) begin
      if (push) begin
         istr_mem[wr_ptr] <= in_istr;
         pc_mem[wr_ptr]   <= in_pc;
      end
   end

endmodule

// File: tb/tb_core_ibuf.sv
// Bench for core_ibuf: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_core_ibuf;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rest;
   logic        flush_en;
   logic [31:0] in_istr;
   logic [31:0] in_pc;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_istr;
   logic [31:0] out_pc;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;

   int unsigned checks;
   int unsigned errors;

   logic [63:0] mdl_q[$];

   core_ibuf #(.DEPTH(DEPTH), .NOP_ISTR(32'h0000_0013)) dut (
      .clk(clk),
      .rest(rest),
      .flush_en(flush_en),
      .in_istr(in_istr),
      .in_pc(in_pc),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_istr(out_istr),
      .out_pc(out_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue holding exactly what decode has yet to see.
   always @(posedge clk or posedge rest) begin
      if (rest) begin
         mdl_q.delete();
      end else if (flush_en) begin
         mdl_q.delete();
      end else begin
         bit do_pop, do_push;
         do_pop  = (mdl_q.size() != 0) && out_ready;
         do_push = in_valid && (mdl_q.size() != DEPTH);
         if (do_pop)  void'(mdl_q.pop_front());
         if (do_push) mdl_q.push_back({in_istr, in_pc});
      end
   end

   always @(posedge clk) begin
      #1;
      if (mdl_q.size() != 0) begin
         chk("m_out_valid", 32'(out_valid), 32'd1);
         chk("m_out_istr",  out_istr, mdl_q[0][63:32]);
         chk("m_out_pc",    out_pc,   mdl_q[0][31:0]);
      end else begin
         chk("m_out_valid", 32'(out_valid), 32'd0);
         chk("m_out_istr",  out_istr, 32'h0000_0013);
         chk("m_out_pc",    out_pc,   32'h0);
      end
      chk("m_in_ready", 32'(in_ready), 32'(mdl_q.size() != DEPTH));
      chk("m_count",    32'(count),    32'(mdl_q.size()));
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush_en  = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rest      = 1'b1;
      flush_en  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_istr   = 32'h0;
      in_pc     = 32'h0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_out_istr",  out_istr,       32'h0000_0013);
      chk("rst_out_pc",    out_pc,         32'h0);
      step();
      step();
      rest = 1'b0;

      // Fill and block
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_pc    = 32'(4 * i);
         in_istr  = 32'h1000_0000 | 32'(i);
         step();
      end
      chk("fill_count",    32'(count),    32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      in_pc   = 32'h10;
      in_istr = 32'h1000_0010;
      step();
      chk("block_count",  32'(count), 32'd4);
      chk("block_out_pc", out_pc,     32'h0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc",   out_pc,   32'(4 * i));
         chk("drain_istr", out_istr, 32'h1000_0000 | 32'(i));
         step();
         if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'd1);
      end
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_count", 32'(count),     32'd0);
      idle_inputs();
      step();

      // Streaming with wrap
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_pc   = 32'(4 * i);
         in_istr = 32'h2000_0000 | 32'(i);
         step();
         chk("stream_count", 32'(count), 32'd1);
         chk("stream_pc",    out_pc,     32'(4 * i));
      end
      in_valid = 1'b0;
      step();
      chk("stream_empty", 32'(count), 32'd0);
      idle_inputs();

      // Flush together with push and pop
      in_valid = 1'b1;
      in_pc = 32'h20; in_istr = 32'h3000_0020; step();
      in_pc = 32'h24; in_istr = 32'h3000_0024; step();
      chk("pre_flush_count", 32'(count), 32'd2);
      flush_en  = 1'b1;
      out_ready = 1'b1;
      in_pc = 32'h28; in_istr = 32'h3000_0028;
      step();
      chk("flush_count",     32'(count),     32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      flush_en  = 1'b0;
      out_ready = 1'b0;
      in_pc = 32'h100; in_istr = 32'h3000_0100;
      step();
      in_valid = 1'b0;
      chk("post_flush_pc",    out_pc,     32'h100);
      chk("post_flush_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      idle_inputs();

      // Asynchronous reset mid-stream
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_pc   = 32'h40 + 32'(4 * i);
         in_istr = 32'h4000_0000 | 32'(i);
         step();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      #1;
      rest = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_count",     32'(count),     32'd0);
      chk("arst_out_istr",  out_istr,       32'h0000_0013);
      step();
      rest     = 1'b0;
      in_valid = 1'b1;
      in_istr  = 32'h0050_0093;
      in_pc    = 32'h0;
      step();
      in_valid = 1'b0;
      chk("arst_first_valid", 32'(out_valid), 32'd1);
      chk("arst_first_istr",  out_istr,       32'h0050_0093);
      chk("arst_first_pc",    out_pc,         32'h0);
      out_ready = 1'b1;
      step();
      idle_inputs();

      // Random traffic with sporadic flushes
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush_en  = ($urandom_range(0, 63) == 0);
         in_istr   = $urandom;
         in_pc     = $urandom;
         step();
      end
      idle_inputs();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
